// File: rtl/arcade_input_decoder_pkg.sv
// arcade_input_pkg
// Shared constants for the arcade input decoder: PS/2 scan codes and
// prefixes, joystick bit positions, key-state vector layout and the coin
// FSM state type.
package arcade_input_pkg;

  // PS/2 set-2 scan codes (low byte only; the extended flag is separate)
  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_FIRE_A = 8'h29;
  localparam logic [7:0] KEY_FIRE_B = 8'h14;
  localparam logic [7:0] KEY_START1 = 8'h05;
  localparam logic [7:0] KEY_START2 = 8'h06;
  localparam logic [7:0] PFX_BREAK  = 8'hF0;
  localparam logic [7:0] PFX_EXT    = 8'hE0;

  // Joystick word bit positions
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  // Layout of the keyboard key-state vector
  localparam int KS_UP     = 0;
  localparam int KS_DOWN   = 1;
  localparam int KS_LEFT   = 2;
  localparam int KS_RIGHT  = 3;
  localparam int KS_FIRE   = 4;
  localparam int KS_START1 = 5;
  localparam int KS_START2 = 6;
  localparam int KS_WIDTH  = 7;

  // Coin FSM encodings, kept as plain constants for older tooling
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COIN     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    COIN     = ST_COIN,
    WAIT_REL = ST_WAIT_REL
  } coin_state_t;

endpackage

// File: rtl/arcade_input_decoder_if.sv
// arcade_input_decoder_if
// Bundles the host-side inputs and game-side outputs of the decoder.
//   ps2_key     65-bit PS/2 event word from hps_io
//   joystick_0  player-1 joystick word
//   joystick_1  player-2 joystick word
//   rotate      1 = horizontal orientation
//   in0, in1    active-low game input bytes
//   coin_busy   coin FSM not idle
// master drives the host inputs, slave is the decoder.
interface arcade_input_decoder_if;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        coin_busy;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  in0, in1, coin_busy
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output in0, in1, coin_busy
  );
endinterface

// File: rtl/arcade_input_decoder_ps2_btn_latch.sv
// ps2_btn_latch
// Tracks make/break events from the PS/2 key word and keeps one state bit
// per mapped game key.
//   i_clk     system clock
//   i_reset   synchronous active-high reset
//   i_ps2Key  65-bit PS/2 event word
//   o_keys    key-state vector, layout KS_* from arcade_input_pkg
module ps2_btn_latch
  import arcade_input_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [64:0]         i_ps2Key,
  output logic [KS_WIDTH-1:0] o_keys
);

  logic                r_oldToggle;
  logic [KS_WIDTH-1:0] r_keys;
  logic                w_event;
  logic                w_pressed;
  logic                w_extended;
  logic [8:0]          w_code;

  // A break code carries F0 as its prefix, so the extended marker of a
  // release sits one byte further back. Multi-byte sequences such as
  // PRNSCR/PAUSE are squashed to code 0, which matches no key.
  assign w_event    = r_oldToggle != i_ps2Key[64];
  assign w_pressed  = i_ps2Key[15:8] != PFX_BREAK;
  assign w_extended = w_pressed ? (i_ps2Key[15:8] == PFX_EXT)
                                : (i_ps2Key[23:16] == PFX_EXT);
  assign w_code     = (i_ps2Key[63:24] != 40'd0) ? 9'd0
                                                 : {w_extended, i_ps2Key[7:0]};

  // The toggle shadow loads even during reset so that a toggle already
  // flipped while in reset does not look like a fresh event afterwards.
  // Arrow keys match with either extended value; the rest must be plain.
  always_ff @(posedge i_clk) begin
    r_oldToggle <= i_ps2Key[64];
    if (i_reset) begin
      r_keys <= '0;
    end else if (w_event) begin
      if (w_code[7:0] == KEY_UP)    r_keys[KS_UP]    <= w_pressed;
      if (w_code[7:0] == KEY_DOWN)  r_keys[KS_DOWN]  <= w_pressed;
      if (w_code[7:0] == KEY_LEFT)  r_keys[KS_LEFT]  <= w_pressed;
      if (w_code[7:0] == KEY_RIGHT) r_keys[KS_RIGHT] <= w_pressed;
      if (w_code == {1'b0, KEY_FIRE_A} || w_code == {1'b0, KEY_FIRE_B})
        r_keys[KS_FIRE] <= w_pressed;
      if (w_code == {1'b0, KEY_START1}) r_keys[KS_START1] <= w_pressed;
      if (w_code == {1'b0, KEY_START2}) r_keys[KS_START2] <= w_pressed;
    end
  end

  assign o_keys = r_keys;

endmodule

// File: rtl/arcade_input_decoder.sv
// arcade_input_decoder
// Converts PS/2 key events and two joystick words into the active-low
// in0/in1 bytes of the pacman core, and turns a start press into a timed
// coin pulse.
//   clk_sys  system clock
//   reset    synchronous active-high reset
//   bus      arcade_input_decoder_if.slave (ps2_key, joystick_0/1, rotate
//            in; in0, in1, coin_busy out)
// Parameters: COIN_CYCLES = coin pulse length in clk_sys cycles,
//             CNT_W = counter width, 2**CNT_W must exceed COIN_CYCLES.
module arcade_input_decoder
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES = 2457600,
  parameter int CNT_W       = 22
) (
  input logic                   clk_sys,
  input logic                   reset,
  arcade_input_decoder_if.slave bus
);

  logic [KS_WIDTH-1:0] w_keys;
  logic [15:0]         w_joy;
  logic                w_unusedJoyBits;
  logic                w_up, w_down, w_left, w_right;
  logic                w_fire, w_start1, w_start2, w_anyStart;
  logic                w_startRise;
  coin_state_t         r_state, w_nextState;
  logic [CNT_W-1:0]    r_count, w_nextCount;
  logic                r_anyStart, r_startPrev;
  logic [7:0]          r_in0, r_in1;
  logic                r_coinBusy;

  ps2_btn_latch u_latch (
    .i_clk    (clk_sys),
    .i_reset  (reset),
    .i_ps2Key (bus.ps2_key),
    .o_keys   (w_keys)
  );

  assign w_joy           = bus.joystick_0 | bus.joystick_1;
  assign w_unusedJoyBits = ^w_joy[15:7];

  // Merge keyboard and joystick, then rotate the directions a quarter turn
  // when the cabinet is mounted horizontally.
  always_comb begin
    w_up    = w_keys[KS_UP]    | w_joy[JOY_UP];
    w_down  = w_keys[KS_DOWN]  | w_joy[JOY_DOWN];
    w_left  = w_keys[KS_LEFT]  | w_joy[JOY_LEFT];
    w_right = w_keys[KS_RIGHT] | w_joy[JOY_RIGHT];
    if (bus.rotate) begin
      w_up    = w_keys[KS_LEFT]  | w_joy[JOY_LEFT];
      w_down  = w_keys[KS_RIGHT] | w_joy[JOY_RIGHT];
      w_left  = w_keys[KS_DOWN]  | w_joy[JOY_DOWN];
      w_right = w_keys[KS_UP]    | w_joy[JOY_UP];
    end
  end

  assign w_fire      = w_keys[KS_FIRE]   | w_joy[JOY_FIRE];
  assign w_start1    = w_keys[KS_START1] | w_joy[JOY_START1];
  assign w_start2    = w_keys[KS_START2] | w_joy[JOY_START2];
  assign w_anyStart  = w_start1 | w_start2;
  assign w_startRise = r_anyStart & ~r_startPrev;

  // Coin sequencing: one pulse per start press. Edges arriving while a
  // pulse runs or while start is still held are ignored, and the counter
  // rests at zero whenever it is not counting.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      IDLE: begin
        if (w_startRise) begin
          w_nextState = COIN;
          w_nextCount = CNT_W'(COIN_CYCLES - 1);
        end
      end
      COIN: begin
        if (r_count == '0) w_nextState = WAIT_REL;
        else               w_nextCount = r_count - 1'b1;
      end
      WAIT_REL: begin
        if (!r_anyStart) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  // All outputs come from flops. The start level is registered once before
  // edge detection, which puts the coin pulse two edges after the press.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_anyStart  <= 1'b0;
      r_startPrev <= 1'b0;
      r_in0       <= 8'hFF;
      r_in1       <= 8'hFF;
      r_coinBusy  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_count     <= w_nextCount;
      r_anyStart  <= w_anyStart;
      r_startPrev <= r_anyStart;
      r_in0       <= ~{2'b00, (r_state == COIN), w_fire, w_down, w_right,
                       w_left, w_up};
      r_in1       <= ~{1'b0, w_start2, w_start1, 5'b00000};
      r_coinBusy  <= (w_nextState != IDLE);
    end
  end

  assign bus.in0       = r_in0;
  assign bus.in1       = r_in1;
  assign bus.coin_busy = r_coinBusy;

endmodule
